// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote sampling and a first-word-fall-through receive FIFO.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_fifo #(
    parameter int MAX_DATA   = 9,
    parameter int OSR        = 16,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic [3:0]                    data_size,
    input  logic                          parity_en,
    input  logic [1:0]                    parity_mode,
    input  logic                          stop_bit_size,
    input  logic                          rd_en,
    output logic [MAX_DATA-1:0]           rd_data,
    output logic                          rd_err_parity,
    output logic                          rd_err_frame,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    input  logic                          clr_overflow,
`ifdef UART_RX_BREAK_DETECT_EN
    output logic                          break_det,
`endif
    output logic                          busy
);
    localparam int TW = $clog2(OSR);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = MAX_DATA + 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT} state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [3:0] eff_size(input logic [3:0] ds);
        if (ds < 4'd5 || ds > 4'(MAX_DATA)) return 4'(MAX_DATA);
        return ds;
    endfunction

    function automatic logic par_expected(input logic [1:0] mode, input logic [MAX_DATA-1:0] d);
        return mode[0] ^ (mode[1] & (^d));
    endfunction

    state_t             r_state, w_state_nxt;
    logic               r_rx_meta, r_rx_s, r_rx_d;
    logic [DIV_W-1:0]   r_baud, r_div_cnt;
    logic [3:0]         r_size, r_bit_cnt;
    logic               r_par_en, r_stop2, r_stop_cnt;
    logic [1:0]         r_par_mode;
    logic [TW-1:0]      r_t;
    logic               r_s0, r_s1;
    logic [MAX_DATA-1:0] r_data;
    logic               r_par_err, r_frm_err;
    logic               r_push;
    logic [EW-1:0]      r_push_ent;
    logic [EW-1:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wptr, r_rptr;
    logic [LW-1:0]      r_count;
    logic               r_overflow;
    logic               w_start, w_tick, w_dec, w_end, w_bit, w_frm_now, w_finish, w_push;
    logic               w_brk_now, w_rd, w_wr, w_drop;
    logic [EW-1:0]      w_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    assign w_start = (r_state == S_IDLE) && r_rx_d && !r_rx_s;

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_baud     <= baud_div;
            r_size     <= eff_size(data_size);
            r_par_en   <= parity_en;
            r_par_mode <= parity_mode;
            r_stop2    <= stop_bit_size;
        end
    end

    // Tick phase restarts at every start edge so bit centres track the falling edge.
    assign w_tick = (r_state != S_IDLE) && (r_div_cnt == r_baud);
    assign w_dec  = w_tick && (r_t == TW'(OSR/2 + 1));
    assign w_end  = w_tick && (r_t == TW'(OSR - 1));
    assign w_bit  = maj3(r_s0, r_s1, r_rx_s);

    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE) begin
            r_div_cnt <= '0;
            r_t       <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_t       <= (r_t == TW'(OSR - 1)) ? '0 : r_t + 1'b1;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tick && r_t == TW'(OSR/2 - 1)) r_s0 <= r_rx_s;
        if (w_tick && r_t == TW'(OSR/2))     r_s1 <= r_rx_s;
    end

    always_ff @(posedge clk) begin
        if (w_start) begin
            r_data     <= '0;
            r_bit_cnt  <= '0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_stop_cnt <= 1'b0;
        end else begin
            case (r_state)
                S_DATA: begin
                    if (w_dec) r_data <= r_data | (MAX_DATA'(w_bit) << r_bit_cnt);
                    if (w_end) r_bit_cnt <= r_bit_cnt + 1'b1;
                end
                S_PARITY: if (w_dec) r_par_err <= w_bit ^ par_expected(r_par_mode, r_data);
                S_STOP: begin
                    if (w_dec && !w_bit) r_frm_err <= 1'b1;
                    if (w_end) r_stop_cnt <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign w_frm_now = r_frm_err | ((r_state == S_STOP) & w_dec & ~w_bit);

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE:   if (w_start) w_state_nxt = S_START;
            S_START: begin
                if (w_dec && w_bit)  w_state_nxt = S_IDLE;
                else if (w_end)      w_state_nxt = S_DATA;
            end
            S_DATA:   if (w_end && r_bit_cnt == r_size - 4'd1) w_state_nxt = r_par_en ? S_PARITY : S_STOP;
            S_PARITY: if (w_end) w_state_nxt = S_STOP;
            // Finishing at mid stop bit leaves half a bit of margin for the next start edge.
            S_STOP: begin
                if (w_dec && r_stop_cnt == r_stop2) begin
                    if (w_frm_now && !r_rx_s) begin
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_finish    = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic r_brk, r_brk_det;

    always_ff @(posedge clk) begin
        if (w_start) r_brk <= 1'b1;
        else if (w_dec && w_bit && (r_state == S_DATA || r_state == S_PARITY ||
                 (r_state == S_STOP && !r_stop_cnt))) r_brk <= 1'b0;
    end

    assign w_brk_now = r_brk & ~((r_state == S_STOP) & w_dec & ~r_stop_cnt & w_bit);

    always_ff @(posedge clk) begin
        if (rst) r_brk_det <= 1'b0;
        else     r_brk_det <= w_finish & w_brk_now;
    end

    assign break_det = r_brk_det;
`else
    assign w_brk_now = 1'b0;
`endif

    assign w_push = w_finish & ~w_brk_now;

    always_ff @(posedge clk) begin
        if (rst) r_push <= 1'b0;
        else     r_push <= w_push;
        r_push_ent <= {w_frm_now, r_par_err, r_data};
    end

    // A push into a full FIFO still lands when the head is popped in the same cycle.
    assign w_rd   = rd_en & ~empty;
    assign w_wr   = r_push & (~full | w_rd);
    assign w_drop = r_push & full & ~w_rd;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr] <= r_push_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + 1'b1;
            if (w_rd) r_rptr <= r_rptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop)            r_overflow <= 1'b1;
            else if (clr_overflow) r_overflow <= 1'b0;
        end
    end

    assign w_head        = r_mem[r_rptr];
    assign empty         = (r_count == '0);
    assign full          = (r_count == LW'(FIFO_DEPTH));
    assign level         = r_count;
    assign overflow      = r_overflow;
    assign rd_data       = empty ? '0 : w_head[MAX_DATA-1:0];
    assign rd_err_parity = ~empty & w_head[MAX_DATA];
    assign rd_err_frame  = ~empty & w_head[MAX_DATA+1];
    assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: a frame-level model queues expected FIFO entries and a
// monitor pops the DUT FIFO and compares whenever it holds data.
module tb_uart_rx_fifo;
    localparam int MAX_DATA   = 9;
    localparam int OSR        = 16;
    localparam int DIV_W      = 16;
    localparam int FIFO_DEPTH = 16;

    logic                        clk = 1'b0;
    logic                        rst, rx, parity_en, stop_bit_size, rd_en, clr_overflow;
    logic [DIV_W-1:0]            baud_div;
    logic [3:0]                  data_size;
    logic [1:0]                  parity_mode;
    logic [MAX_DATA-1:0]         rd_data;
    logic                        rd_err_parity, rd_err_frame, empty, full, overflow, busy;
    logic [$clog2(FIFO_DEPTH):0] level;
`ifdef UART_RX_BREAK_DETECT_EN
    logic                        break_det;
    int                          brk_seen = 0;
    int                          brk_exp  = 0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    bit          auto_read = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.MAX_DATA(MAX_DATA), .OSR(OSR), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .rx(rx), .baud_div(baud_div), .data_size(data_size),
        .parity_en(parity_en), .parity_mode(parity_mode), .stop_bit_size(stop_bit_size),
        .rd_en(rd_en), .rd_data(rd_data), .rd_err_parity(rd_err_parity),
        .rd_err_frame(rd_err_frame), .empty(empty), .full(full), .level(level),
        .overflow(overflow), .clr_overflow(clr_overflow),
`ifdef UART_RX_BREAK_DETECT_EN
        .break_det(break_det),
`endif
        .busy(busy)
    );

`ifdef UART_RX_BREAK_DETECT_EN
    always @(posedge clk) if (break_det) brk_seen++;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops one entry per cycle whenever the FIFO is non-empty and reading is enabled.
    initial begin
        logic [10:0] e;
        rd_en = 1'b0;
        forever begin
            @(negedge clk);
            rd_en = 1'b0;
            if (auto_read && !empty && !rst) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_entry: got data 0x%0h, expected no entry", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e[8:0]));
                    check("rd_err_parity", 32'(rd_err_parity), 32'(e[9]));
                    check("rd_err_frame", 32'(rd_err_frame), 32'(e[10]));
                end
                rd_en = 1'b1;
            end
        end
    end

    function automatic int bit_clks();
        return (int'(baud_div) + 1) * OSR;
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame on rx and queues the entry the receiver should store for it.
    task automatic send_frame(input logic [8:0] d, input logic [3:0] ds, input logic pen,
                              input logic [1:0] pm, input logic s2, input logic bad_par,
                              input logic [1:0] stopv, input bit glitch, input bit expect_push,
                              input int hold);
        int nb, ones, bc, bd;
        logic [8:0] dm;
        logic pb, brk, ferr;
        data_size     = ds;
        parity_en     = pen;
        parity_mode   = pm;
        stop_bit_size = s2;
        nb   = (ds < 5 || ds > 9) ? 9 : int'(ds);
        dm   = d & 9'((1 << nb) - 1);
        ones = $countones(dm);
        case (pm)
            2'b11:   pb = (ones % 2 == 0);
            2'b10:   pb = (ones % 2 == 1);
            2'b01:   pb = 1'b1;
            default: pb = 1'b0;
        endcase
        pb   = pb ^ bad_par;
        ferr = !stopv[0] || (s2 && !stopv[1]);
        brk  = (dm == 9'd0) && (!pen || !pb) && !stopv[0];
`ifdef UART_RX_BREAK_DETECT_EN
        if (brk) begin
            brk_exp++;
            expect_push = 1'b0;
        end
`else
        brk = 1'b0;
`endif
        if (expect_push) exp_q.push_back({ferr, pen & bad_par, dm});
        bc = bit_clks();
        bd = int'(baud_div) + 1;
        rx = 1'b0;
        wait_cycles(bc);
        for (int i = 0; i < nb; i++) begin
            rx = dm[i];
            if (glitch && i == 0) begin
                wait_cycles(bc / 2);
                rx = ~dm[0];
                wait_cycles(bd);
                rx = dm[0];
                wait_cycles(bc - bc / 2 - bd);
            end else begin
                wait_cycles(bc);
            end
        end
        if (pen) begin
            rx = pb;
            wait_cycles(bc);
        end
        rx = stopv[0];
        wait_cycles(bc);
        if (s2) begin
            rx = stopv[1];
            wait_cycles(bc);
        end
        if (hold > 0) begin
            wait_cycles(hold * bc);
            check("held_low_level", 32'(level), 32'd0);
            check("held_low_busy", 32'(busy), 32'd1);
        end
        rx = 1'b1;
        if (rx !== (s2 ? stopv[1] : stopv[0]) || hold > 0) wait_cycles(bc);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || !empty) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("drain_remaining", 32'(exp_q.size()), 32'd0);
        check("drain_empty", 32'(empty), 32'd1);
    endtask

    initial begin
        rst = 1'b1; rx = 1'b1; clr_overflow = 1'b0; baud_div = 16'd3;
        data_size = 4'd8; parity_en = 1'b0; parity_mode = 2'b00; stop_bit_size = 1'b0;
        wait_cycles(5);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_errs", 32'({rd_err_frame, rd_err_parity}), 32'd0);
        rst = 1'b0;
        wait_cycles(5);

        // 8N1 0xA5 held in the FIFO, then read out.
        send_frame(9'h0A5, 4'd8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 0);
        check("a5_level", 32'(level), 32'd1);
        check("a5_head", 32'(rd_data), 32'h0A5);
        auto_read = 1'b1;
        wait_drain();

        // 7E1 0x41 with a wrong parity bit.
        send_frame(9'h041, 4'd7, 1'b1, 2'b10, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 0);
        wait_drain();

        // False start, then a glitch inside data bit 0.
        rx = 1'b0;
        wait_cycles(5 * (int'(baud_div) + 1));
        rx = 1'b1;
        wait_cycles(3 * bit_clks());
        check("false_start_busy", 32'(busy), 32'd0);
        check("false_start_level", 32'(level), 32'd0);
        send_frame(9'h05A, 4'd8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 0);
        wait_drain();

        // 8N2 with bad second stop bit and a long low line afterwards.
        send_frame(9'h0C3, 4'd8, 1'b0, 2'b00, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 3);
        wait_drain();

        // Randomised frames across formats and baud rates.
        for (int k = 0; k < 24; k++) begin
            logic [3:0] ds;
            logic [1:0] sv;
            baud_div = 16'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) ds = ($urandom_range(0, 1) == 1) ? 4'd13 : 4'd0;
            else                           ds = 4'($urandom_range(5, 9));
            sv[0] = ($urandom_range(0, 7) != 0);
            sv[1] = ($urandom_range(0, 7) != 0);
            send_frame(9'($urandom), ds, 1'($urandom), 2'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), sv, 1'b0, 1'b1, 0);
        end
        wait_drain();

        // 17 back-to-back 9N1 frames with no reads: the last one is dropped.
        baud_div  = 16'd3;
        auto_read = 1'b0;
        for (int i = 0; i <= FIFO_DEPTH; i++)
            send_frame(9'(9'h100 + i), 4'd9, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0,
                       (i < FIFO_DEPTH), 0);
        wait_cycles(10);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_level", 32'(level), 32'(FIFO_DEPTH));
        check("ovf_flag", 32'(overflow), 32'd1);
        auto_read = 1'b1;
        wait_drain();
        check("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        wait_cycles(1);
        clr_overflow = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Reset in the middle of 0x3C, then a clean 0x5A.
        data_size = 4'd8; parity_en = 1'b0; stop_bit_size = 1'b0;
        rx = 1'b0;
        wait_cycles(bit_clks());
        for (int i = 0; i < 3; i++) begin
            rx = (i == 2);
            wait_cycles(bit_clks());
        end
        rst = 1'b1;
        wait_cycles(2);
        rx  = 1'b1;
        rst = 1'b0;
        wait_cycles(1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        wait_cycles(bit_clks());
        check("midrst_level", 32'(level), 32'd0);
        send_frame(9'h05A, 4'd8, 1'b0, 2'b00, 1'b0, 1'b0, 2'b11, 1'b0, 1'b1, 0);
        wait_drain();

`ifdef UART_RX_BREAK_DETECT_EN
        check("break_count", 32'(brk_seen), 32'(brk_exp));
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
